rom_burst_arbiter: RTL and testbench
====================================

Name: rom_burst_arbiter

Overview:
- Shares one synchronous-read ROM (1-cycle read latency, registered output) between REQUESTERS clients, e.g. neuron units fetching weight or bias vectors.
- Each client requests a burst of consecutive words: a base address plus a length.
- The block arbitrates round-robin, grants one burst at a time and issues one address per cycle.
- Returned data is streamed on a shared bus tagged with the owner index; there is no backpressure.

Parameters:
REQUESTERS, 4, number of clients (>= 2)
WIDTH, 16, ROM word width in bits
DEPTH, 10, ROM depth in words; AW = $clog2(DEPTH), LW = $clog2(DEPTH+1), IW = $clog2(REQUESTERS)

Ports:
clock  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous active-low reset
request  input  [REQUESTERS]  per-client burst request, held until that client's done
base_address  input  [REQUESTERS][AW]  per-client first address, sampled at grant
length  input  [REQUESTERS][LW]  per-client word count (0..DEPTH), sampled at grant
grant  output  [REQUESTERS]  one-hot, high while that client's burst is being issued
done  output  [REQUESTERS]  one-cycle pulse, burst complete
rom_address  output  AW  address to ROM
rom_data  input  WIDTH  ROM registered output
data_out  output  WIDTH  returned word (rom_data passed through)
data_valid  output  1  data_out holds a burst word this cycle
data_owner  output  IW  client index of the current data_out
data_last  output  1  final word of the burst

Behaviour:
- Reset (async assert, sync release): state IDLE, all outputs 0, rr pointer = REQUESTERS-1 (client 0 wins first).
- FSM states: IDLE, BURST, DRAIN.
- IDLE: if any request bit is set, pick the first set bit searching from pointer+1 upward, modulo REQUESTERS.
  - Latch base_address, length and index; update pointer to the winner.
  - length > 0: go to BURST with address register = base and count = length.
  - length = 0: go to DRAIN with no issue.
  - No request: stay in IDLE.
- BURST: grant[owner]=1; rom_address = address register; one issue per cycle.
  - Each cycle: address increments, wrapping DEPTH-1 -> 0; count decrements.
  - When count reaches 1 (last issue), go to DRAIN.
- Issue pipeline: an issue flag is registered once; it drives data_valid, data_owner and data_last.
  - Data therefore appears exactly 1 cycle after its address is presented (ROM latency).
  - data_out = rom_data combinationally; the ROM output is already registered.
- DRAIN (one cycle): last word present (data_valid=1, data_last=1), done[owner]=1; then go to IDLE.
  - For length 0: done pulses in DRAIN with data_valid=0.
  - A client must drop request on the edge after done. Re-arbitration happens in the following IDLE cycle, so a held request is re-granted as a new burst.
- Latency: request seen in IDLE cycle t -> first rom_address at t+1 -> first data_valid at t+2 -> done at t+1+length (t+1 for length 0).
- Gap between bursts: exactly one IDLE cycle after DRAIN.
- Request dropped mid-burst: ignored; the burst completes and done still pulses.
- base_address/length changing after grant: ignored; values were latched at grant.
- length > DEPTH: clamp to DEPTH.
- rom_address is 0 outside BURST.
- Reset mid-burst: the burst is abandoned with no done and no further data_valid; the ROM output is ignored until a new burst.

Decomposition:
- Package rom_arbiter_pkg holds:
  - state enum type (IDLE, BURST, DRAIN);
  - a function computing the next round-robin winner from the request vector and pointer.
- Sub-module rr_arbiter (combinational winner select plus registered pointer, REQUESTERS parameter) is natural, and reusable by later shared-resource controllers.
- The ROM itself stays outside; connect it to rom_address/rom_data at the top level.

Test Plan:
- Single burst: request[0] with base 3, length 4, ROM[i]=i+100.
  - Required: rom_address 3,4,5,6 on cycles 1-4.
  - Required: data_valid cycles 2-5 carrying 103..106, owner 0.
  - Required: data_last and done[0] at cycle 5; grant[0] high cycles 1-4.
- Contention: request[0] and request[2] both assert at cycle 0 with length 2 each.
  - Required: client 0 served first, then client 2 after one IDLE gap.
  - Required: if client 0 re-requests while 2 is active, 0 is served next; if both are held, service strictly alternates 0,2,0,2.
- Wrap: base 8, length 4, DEPTH 10.
  - Required: rom_address 8,9,0,1; data ROM[8],ROM[9],ROM[0],ROM[1].
- Zero length: request[1] with length 0.
  - Required: done[1] one cycle after grant decision; no data_valid, no grant pulse; next request is arbitrated normally.
- Robustness: drop request[0] at cycle 2 of a length-5 burst.
  - Required: all 5 words are still delivered and done[0] pulses.
- Reset: assert reset_n=0 mid-burst.
  - Required: all outputs 0 asynchronously.
  - Required: after release, a new request from client 0 wins and returns correct data.

Source files
------------

// File: rtl/rom_arbiter_pkg.sv
// Shared types and the round-robin selection helper for the ROM burst arbiter
// and other shared-resource controllers.
package rom_arbiter_pkg;

  localparam int unsigned RR_MAX = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic       found;
    logic [4:0] index;
  } rr_pick_t;

  // First set request bit searching upward from ptr+1, modulo n.
  function automatic rr_pick_t rr_next(input logic [RR_MAX-1:0] req,
                                       input int unsigned n,
                                       input int unsigned ptr);
    rr_pick_t    r;
    int unsigned idx;
    r = '0;
    for (int unsigned i = 1; i <= RR_MAX; i++) begin
      if (i <= n && !r.found) begin
        idx = (ptr + i) % n;
        if (req[idx[4:0]]) begin
          r.found = 1'b1;
          r.index = idx[4:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin winner select with a registered pointer; the pointer moves to
// the winner whenever the owner accepts the grant.
module rr_arbiter
  import rom_arbiter_pkg::*;
#(
  parameter  int unsigned REQUESTERS = 4,
  localparam int unsigned IW         = $clog2(REQUESTERS)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [REQUESTERS-1:0] request,
  input  logic                  accept,
  output logic                  any,
  output logic [IW-1:0]         winner
);

  logic [IW-1:0] pointer;
  rr_pick_t      pick;

  always_comb begin
    pick   = rr_next(RR_MAX'(request), REQUESTERS, 32'(pointer));
    any    = pick.found;
    winner = IW'(pick.index);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pointer <= IW'(REQUESTERS - 1);
    end else if (accept && any) begin
      pointer <= winner;
    end
  end

endmodule

// File: rtl/rom_burst_arbiter.sv
// Shares one registered-output ROM between several clients, serving one
// round-robin granted burst at a time and streaming tagged data back.
module rom_burst_arbiter
  import rom_arbiter_pkg::*;
#(
  parameter  int unsigned REQUESTERS = 4,
  parameter  int unsigned WIDTH      = 16,
  parameter  int unsigned DEPTH      = 10,
  localparam int unsigned AW         = $clog2(DEPTH),
  localparam int unsigned LW         = $clog2(DEPTH + 1),
  localparam int unsigned IW         = $clog2(REQUESTERS)
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic [REQUESTERS-1:0]          request,
  input  logic [REQUESTERS-1:0][AW-1:0]  base_address,
  input  logic [REQUESTERS-1:0][LW-1:0]  length,
  output logic [REQUESTERS-1:0]          grant,
  output logic [REQUESTERS-1:0]          done,
  output logic [AW-1:0]                  rom_address,
  input  logic [WIDTH-1:0]               rom_data,
  output logic [WIDTH-1:0]               data_out,
  output logic                           data_valid,
  output logic [IW-1:0]                  data_owner,
  output logic                           data_last
);

  localparam logic [LW-1:0] DEPTH_L   = LW'(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_t        state;
  logic [IW-1:0] owner;
  logic [AW-1:0] address;
  logic [LW-1:0] count;
  logic          issue;
  logic          issue_last;
  logic [IW-1:0] issue_owner;
  logic          any;
  logic [IW-1:0] winner;
  logic [LW-1:0] winner_length;

  rr_arbiter #(.REQUESTERS(REQUESTERS)) u_rr (
    .clock   (clock),
    .reset_n (reset_n),
    .request (request),
    .accept  (state == IDLE),
    .any     (any),
    .winner  (winner)
  );

  assign winner_length = (length[winner] > DEPTH_L) ? DEPTH_L : length[winner];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      owner   <= '0;
      address <= '0;
      count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any) begin
            owner   <= winner;
            address <= base_address[winner];
            count   <= winner_length;
            state   <= (winner_length == '0) ? DRAIN : BURST;
          end
        end
        BURST: begin
          address <= (address == LAST_ADDR) ? '0 : address + AW'(1);
          count   <= count - LW'(1);
          if (count == LW'(1)) state <= DRAIN;
        end
        DRAIN:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Issue flag tracks the ROM's one-cycle read latency.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      issue       <= 1'b0;
      issue_last  <= 1'b0;
      issue_owner <= '0;
    end else begin
      issue       <= (state == BURST);
      issue_last  <= (state == BURST) && (count == LW'(1));
      issue_owner <= (state == BURST) ? owner : '0;
    end
  end

  always_comb begin
    grant       = (state == BURST) ? (REQUESTERS'(1) << owner) : '0;
    done        = (state == DRAIN) ? (REQUESTERS'(1) << owner) : '0;
    rom_address = (state == BURST) ? address : '0;
    data_valid  = issue;
    data_last   = issue_last;
    data_owner  = issue_owner;
    // Stale ROM output (e.g. after a reset mid-burst) never leaks out.
    data_out    = issue ? rom_data : '0;
  end

endmodule

// File: tb/tb_rom_burst_arbiter.sv
// Randomized bench for rom_burst_arbiter against a transaction-level timeline model.
module tb_rom_burst_arbiter;

  localparam int R    = 4;
  localparam int W    = 16;
  localparam int D    = 10;
  localparam int AW   = 4;
  localparam int LW   = 4;
  localparam int IW   = 2;
  localparam int NCYC = 3000;
  localparam int NA   = NCYC + 40;

  logic                  clock = 1'b0;
  logic                  reset_n;
  logic [R-1:0]          request;
  logic [R-1:0][AW-1:0]  base_address;
  logic [R-1:0][LW-1:0]  length;
  logic [R-1:0]          grant, done;
  logic [AW-1:0]         rom_address;
  logic [W-1:0]          rom_data, data_out;
  logic                  data_valid, data_last;
  logic [IW-1:0]         data_owner;

  logic [W-1:0] rom_mem [D];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [R-1:0] exp_grant [NA];
  logic [R-1:0] exp_done  [NA];
  int           exp_addr  [NA];
  logic         exp_valid [NA];
  logic         exp_last  [NA];
  int           exp_data  [NA];
  int           exp_owner [NA];

  int           m_ptr;
  int           next_decide;
  logic [R-1:0] busy;
  bit           did_reset = 0;
  bit           force0    = 0;

  rom_burst_arbiter #(.REQUESTERS(R), .WIDTH(W), .DEPTH(D)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .request      (request),
    .base_address (base_address),
    .length       (length),
    .grant        (grant),
    .done         (done),
    .rom_address  (rom_address),
    .rom_data     (rom_data),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .data_owner   (data_owner),
    .data_last    (data_last)
  );

  always #5 clock = ~clock;

  always @(posedge clock) rom_data <= rom_mem[rom_address];

  task automatic check_eq(input string tag, input int got, input int want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s cycle %0d: got %0d, expected %0d", tag, cyc, got, want);
  endtask

  task automatic check_zero(input string pfx);
    check_eq({pfx, ".grant"},       int'(grant),       0);
    check_eq({pfx, ".done"},        int'(done),        0);
    check_eq({pfx, ".rom_address"}, int'(rom_address), 0);
    check_eq({pfx, ".data_valid"},  int'(data_valid),  0);
    check_eq({pfx, ".data_out"},    int'(data_out),    0);
    check_eq({pfx, ".data_owner"},  int'(data_owner),  0);
    check_eq({pfx, ".data_last"},   int'(data_last),   0);
  endtask

  task automatic clear_from(input int c);
    for (int i = c; i < NA; i++) begin
      exp_grant[i] = '0; exp_done[i] = '0; exp_addr[i] = 0;
      exp_valid[i] = 1'b0; exp_last[i] = 1'b0; exp_data[i] = 0; exp_owner[i] = 0;
    end
  endtask

  task automatic compare(input int c);
    check_eq("grant",       int'(grant),       int'(exp_grant[c]));
    check_eq("done",        int'(done),        int'(exp_done[c]));
    check_eq("rom_address", int'(rom_address), exp_addr[c]);
    check_eq("data_valid",  int'(data_valid),  int'(exp_valid[c]));
    check_eq("data_last",   int'(data_last),   int'(exp_last[c]));
    if (exp_valid[c]) begin
      check_eq("data_out",   int'(data_out),   exp_data[c]);
      check_eq("data_owner", int'(data_owner), exp_owner[c]);
    end
  endtask

  task automatic scramble(input int i);
    base_address[i] = AW'($urandom_range(D - 1, 0));
    length[i]       = LW'($urandom_range(15, 0));
  endtask

  task automatic drive(input int c);
    for (int i = 0; i < R; i++) begin
      if (c == 0) begin
        if (i == 0) begin
          request[0] = 1'b1; base_address[0] = AW'(3); length[0] = LW'(4);
        end
      end else if (force0 && i == 0) begin
        request[0] = 1'b1;
        base_address[0] = AW'($urandom_range(D - 1, 0));
        length[0] = LW'($urandom_range(D, 1));
      end else if (exp_done[c][i]) begin
        request[i] = 1'b0;
        busy[i]    = 1'b0;
      end else if (busy[i]) begin
        if ($urandom % 8 == 0)  scramble(i);
        if ($urandom % 12 == 0) request[i] = 1'b0;
      end else if (request[i]) begin
        if ($urandom % 10 == 0) scramble(i);
      end else if ($urandom % 4 == 0) begin
        request[i] = 1'b1;
        scramble(i);
      end
    end
    force0 = 0;
  endtask

  // Predicts the full output timeline of one burst at the moment it is granted.
  task automatic decide(input int c);
    int found, idx, len, b, a;
    found = -1;
    for (int k = 1; k <= R; k++) begin
      idx = (m_ptr + k) % R;
      if (found < 0 && request[idx]) found = idx;
    end
    if (found < 0) begin
      next_decide = c + 1;
      return;
    end
    m_ptr       = found;
    busy[found] = 1'b1;
    len = (int'(length[found]) > D) ? D : int'(length[found]);
    b   = int'(base_address[found]);
    for (int k = 0; k < len; k++) begin
      a = (b + k) % D;
      exp_grant[c + 1 + k][found] = 1'b1;
      exp_addr[c + 1 + k]  = a;
      exp_valid[c + 2 + k] = 1'b1;
      exp_data[c + 2 + k]  = int'(rom_mem[a]);
      exp_owner[c + 2 + k] = found;
      exp_last[c + 2 + k]  = (k == len - 1);
    end
    exp_done[c + 1 + len][found] = 1'b1;
    next_decide = c + 2 + len;
  endtask

  task automatic do_reset(input int c);
    reset_n = 1'b0;
    #1;
    check_zero("async_reset");
    request = '0;
    busy    = '0;
    @(negedge clock);
    check_zero("reset_hold");
    reset_n     = 1'b1;
    m_ptr       = R - 1;
    clear_from(c + 1);
    next_decide = c + 1;
    did_reset   = 1;
    force0      = 1;
  endtask

  initial begin
    for (int i = 0; i < D; i++) rom_mem[i] = W'($urandom);
    reset_n      = 1'b0;
    request      = '0;
    base_address = '0;
    length       = '0;
    busy         = '0;
    m_ptr        = R - 1;
    clear_from(0);
    repeat (2) @(negedge clock);
    check_zero("reset");
    reset_n     = 1'b1;
    next_decide = 0;
    for (int k = 0; k < NCYC; k++) begin
      @(negedge clock);
      cyc = k;
      compare(k);
      if (!did_reset && k >= NCYC / 2 && exp_grant[k] != '0) begin
        do_reset(k);
      end else begin
        drive(k);
        if (k == next_decide) decide(k);
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
